// File: rtl/vote_result_reader.sv
// Result-readout controller: puts the voting machine in result mode, steps through the four
// candidate buttons, captures each led tally, then reports winner/tie. Optional macro:
// VOTE_READER_STABILITY_CHECK_EN (compare led in last PRESS cycle against SAMPLE cycle).
module vote_result_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] led,
    output logic       mode,
    output logic       button1,
    output logic       button2,
    output logic       button3,
    output logic       button4,
    output logic       busy,
    output logic       done,
    output logic [7:0] tally1,
    output logic [7:0] tally2,
    output logic [7:0] tally3,
    output logic [7:0] tally4,
    output logic [1:0] winner,
    output logic       tie,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, ENTER, PRESS, SAMPLE, RELEASE, DONE} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GUARD_LAST  = 16'(GUARD_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [1:0]  idx, idx_nx;
    logic [7:0]  tally_q [4];
    logic [1:0]  win_nx;
    logic        tie_nx;
    logic [7:0]  max_v;
    logic [2:0]  hits;
    logic        press_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 16'd1;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = ENTER;
                    idx_nx   = '0;
                end
            end
            ENTER: if (cnt == GUARD_LAST) begin
                state_nx = PRESS;
                cnt_nx   = '0;
            end
            PRESS: if (cnt == SETTLE_LAST) begin
                state_nx = SAMPLE;
                cnt_nx   = '0;
            end
            SAMPLE: begin
                state_nx = RELEASE;
                cnt_nx   = '0;
            end
            RELEASE: if (cnt == GUARD_LAST) begin
                cnt_nx = '0;
                if (idx == 2'd3) begin
                    state_nx = DONE;
                end else begin
                    state_nx = PRESS;
                    idx_nx   = idx + 2'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Strict '>' keeps the lowest index on equal tallies.
    always_comb begin
        win_nx = '0;
        max_v  = tally_q[0];
        hits   = '0;
        for (int i = 1; i < 4; i++) begin
            if (tally_q[i] > max_v) begin
                max_v  = tally_q[i];
                win_nx = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (tally_q[i] == max_v) hits = hits + 3'd1;
        end
        tie_nx = (hits > 3'd1);
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    assign press_nx = (state_nx == PRESS) || (state_nx == SAMPLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            mode    <= 1'b0;
            button1 <= 1'b0;
            button2 <= 1'b0;
            button3 <= 1'b0;
            button4 <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            winner  <= '0;
            tie     <= 1'b0;
            for (int i = 0; i < 4; i++) tally_q[i] <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            mode    <= (state_nx == ENTER) || press_nx || (state_nx == RELEASE);
            busy    <= (state_nx == ENTER) || press_nx || (state_nx == RELEASE);
            done    <= (state_nx == DONE);
            button1 <= press_nx && (idx_nx == 2'd0);
            button2 <= press_nx && (idx_nx == 2'd1);
            button3 <= press_nx && (idx_nx == 2'd2);
            button4 <= press_nx && (idx_nx == 2'd3);
            if (state == SAMPLE) tally_q[idx] <= led;
            if (state == RELEASE && state_nx == DONE) begin
                winner <= win_nx;
                tie    <= tie_nx;
            end
        end
    end

`ifdef VOTE_READER_STABILITY_CHECK_EN
    logic [7:0] led_pre;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_pre <= '0;
            err     <= 1'b0;
        end else begin
            if (state == PRESS && cnt == SETTLE_LAST) led_pre <= led;
            if (state == IDLE && start)              err <= 1'b0;
            else if (state == SAMPLE && led != led_pre) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign tally1 = tally_q[0];
    assign tally2 = tally_q[1];
    assign tally3 = tally_q[2];
    assign tally4 = tally_q[3];

endmodule

// File: tb/tb_vote_result_reader.sv
// Self-checking bench for vote_result_reader: table vectors, random tallies against a
// reference winner model, start-ignore, mid-readout reset and a button/mode safety monitor.
module tb_vote_result_reader;
    localparam int SETTLE = 4;
    localparam int GUARD  = 2;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [7:0] led;
    logic       mode, button1, button2, button3, button4, busy, done, tie, err;
    logic [7:0] tally1, tally2, tally3, tally4;
    logic [1:0] winner;

    vote_result_reader #(.SETTLE_CYCLES(SETTLE), .GUARD_CYCLES(GUARD)) dut (
        .clock(clock), .reset(reset), .start(start), .led(led),
        .mode(mode), .button1(button1), .button2(button2), .button3(button3), .button4(button4),
        .busy(busy), .done(done), .tally1(tally1), .tally2(tally2), .tally3(tally3), .tally4(tally4),
        .winner(winner), .tie(tie), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Voting machine model: shows the selected candidate's count in result mode.
    logic [7:0] cnts [4];
    logic       glitch_en = 1'b0;
    int         b2_hi = 0;
    always @(posedge clock) b2_hi <= button2 ? b2_hi + 1 : 0;
    always @* begin
        led = 8'h00;
        if (button1) led = cnts[0];
        if (button2) led = glitch_en ? ((b2_hi >= SETTLE) ? 8'd5 : 8'd4) : cnts[1];
        if (button3) led = cnts[2];
        if (button4) led = cnts[3];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Safety monitor
    logic mon_en = 1'b0;
    logic rst_at_edge = 1'b0;
    always @(posedge clock) rst_at_edge <= reset;
    int lowrun = 0;
    int prev_any = 0;
    logic prev_mode = 1'b0;
    always @(negedge clock) begin
        int any;
        if (mon_en) begin
            any = int'(button1) + int'(button2) + int'(button3) + int'(button4);
            chk("safety_btn_mode", int'((any > 0 && !mode) || any > 1), 0);
            if (any > 0 && prev_any == 0 && !rst_at_edge)
                chk("guard_before_press", int'(lowrun >= GUARD), 1);
            if (!mode && prev_mode && !rst_at_edge)
                chk("guard_before_mode_fall", int'(lowrun >= GUARD), 1);
            lowrun    = (mode && any == 0) ? lowrun + 1 : 0;
            prev_any  = any;
            prev_mode = mode;
        end
    end

    // Reference: winner is the first candidate no other candidate beats; tie if another equals it.
    task automatic ref_result(input logic [7:0] c [4], output int w, output int t);
        bit dom;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            dom = 1'b1;
            for (int j = 0; j < 4; j++) if (c[j] > c[i]) dom = 1'b0;
            if (dom && w < 0) w = i;
        end
        t = 0;
        for (int j = 0; j < 4; j++) if (j != w && c[j] == c[w]) t = 1;
    endtask

    task automatic readout(input string tag, input bit extra, input logic [7:0] et [4],
                           input int ew, input int etie, input int eerr);
        int nbusy, ndone, done_at;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk({tag, " busy_rise"}, int'(busy), 1);
        chk({tag, " mode_rise"}, int'(mode), 1);
        chk({tag, " err_clear"}, int'(err), 0);
        nbusy = int'(busy); ndone = 0; done_at = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = i;
                chk({tag, " done_busy"}, int'(busy), 0);
                chk({tag, " done_mode"}, int'(mode), 0);
                chk({tag, " tally1"}, int'(tally1), int'(et[0]));
                chk({tag, " tally2"}, int'(tally2), int'(et[1]));
                chk({tag, " tally3"}, int'(tally3), int'(et[2]));
                chk({tag, " tally4"}, int'(tally4), int'(et[3]));
                chk({tag, " winner"}, int'(winner), ew);
                chk({tag, " tie"}, int'(tie), etie);
                chk({tag, " err"}, int'(err), eerr);
            end
            if (extra && (i == 5 || i == 12)) start = 1'b1;
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, nbusy, 30);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " done_latency"}, done_at, 31);
        chk({tag, " hold_winner"}, int'(winner), ew);
        chk({tag, " hold_tally3"}, int'(tally3), int'(et[2]));
    endtask

    typedef struct {
        logic [7:0] c [4];
        int         w;
        int         t;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int w, t;
        logic [7:0] et [4];
        tbl[0].c = '{8'd3, 8'd1, 8'd5, 8'd0};     tbl[0].w = 2; tbl[0].t = 0;
        tbl[1].c = '{8'd7, 8'd7, 8'd2, 8'd7};     tbl[1].w = 0; tbl[1].t = 1;
        tbl[2].c = '{8'd0, 8'd0, 8'd0, 8'd0};     tbl[2].w = 0; tbl[2].t = 1;
        tbl[3].c = '{8'd0, 8'd0, 8'd0, 8'd255};   tbl[3].w = 3; tbl[3].t = 0;
        tbl[4].c = '{8'd255, 8'd255, 8'd0, 8'd0}; tbl[4].w = 0; tbl[4].t = 1;
        tbl[5].c = '{8'd1, 8'd2, 8'd3, 8'd4};     tbl[5].w = 3; tbl[5].t = 0;
        tbl[6].c = '{8'd0, 8'd200, 8'd199, 8'd200}; tbl[6].w = 1; tbl[6].t = 1;
        tbl[7].c = '{8'd128, 8'd127, 8'd129, 8'd1}; tbl[7].w = 2; tbl[7].t = 0;

        reset = 1'b1; start = 1'b0;
        for (int i = 0; i < 4; i++) cnts[i] = 8'd0;
        repeat (3) @(negedge clock);
        chk("rst mode", int'(mode), 0);
        chk("rst buttons", int'({button1, button2, button3, button4}), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst tallies", int'({tally1, tally2, tally3, tally4}), 0);
        chk("rst winner", int'(winner), 0);
        chk("rst tie", int'(tie), 0);
        chk("rst err", int'(err), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 8; v++) begin
            cnts = tbl[v].c;
            readout($sformatf("vec%0d", v), 1'b0, tbl[v].c, tbl[v].w, tbl[v].t, 0);
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++)
                cnts[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            ref_result(cnts, w, t);
            readout($sformatf("rnd%0d", r), 1'b0, cnts, w, t, 0);
        end

        cnts = tbl[0].c;
        readout("start_ignored", 1'b1, tbl[0].c, 2, 0, 0);

        // Reset 10 cycles into a readout, after tally1 has been captured.
        cnts = '{8'd9, 8'd8, 8'd7, 8'd6};
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst mode", int'(mode), 0);
        chk("midrst buttons", int'({button1, button2, button3, button4}), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst tallies", int'({tally1, tally2, tally3, tally4}), 0);
        reset = 1'b0;
        readout("after_rst", 1'b0, cnts, 0, 0, 0);

`ifdef VOTE_READER_STABILITY_CHECK_EN
        cnts = '{8'd1, 8'd4, 8'd2, 8'd3};
        glitch_en = 1'b1;
        et = '{8'd1, 8'd5, 8'd2, 8'd3};
        readout("glitch", 1'b0, et, 1, 0, 1);
        glitch_en = 1'b0;
        readout("post_glitch", 1'b0, cnts, 1, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
